// File: rtl/dsp_xfade_switch.sv
// dsp_xfade_switch: N-input sample selector with a linear crossfade on
// every select change. A fade runs over F = 2^LGFADE input samples and
// moves the output from the old channel to the new one. All state moves
// only on i_ce, so the block fits a clock-enabled filter chain.
//
// Optional build macro DSPSWITCH_MUTE_EN adds an i_mute input. Mute is a
// virtual channel NIN whose sample is always zero. Entering and leaving
// mute uses the same fade machine as a normal select change.
//
// Handshake: each i_ce pulse produces exactly one o_ce pulse two clocks
// later. o_sample is valid on o_ce and holds its value between pulses.
// There is no back-pressure, and i_ce may be high on every clock.
module dsp_xfade_switch #(
    parameter  int NIN    = 4,
    parameter  int DW     = 16,
    parameter  int LGFADE = 4,
    localparam int LGNIN  = $clog2(NIN)
) (
    input  logic              i_clk,
    input  logic              i_areset_n,
    input  logic              i_ce,
    input  logic [NIN*DW-1:0] i_samples,
    input  logic [LGNIN-1:0]  i_sel,
    output logic              o_ce,
    output logic [DW-1:0]     o_sample,
    output logic              o_busy,
    output logic [LGNIN-1:0]  o_sel
`ifdef DSPSWITCH_MUTE_EN
    ,
    input  logic              i_mute
`endif
);

    // Internal select width. Under mute, one extra bit lets the virtual
    // channel NIN be represented even when NIN is a power of two.
`ifdef DSPSWITCH_MUTE_EN
    localparam int SW = LGNIN + 1;
`else
    localparam int SW = LGNIN;
`endif
    localparam int NCH = 1 << SW;
    localparam int KW  = LGFADE + 1;          // k spans 0..F
    localparam int AW  = DW + LGFADE + 1;     // accumulator width
    localparam int F   = 1 << LGFADE;

    localparam logic [KW-1:0]    F_K    = KW'(F);
    localparam logic [KW-1:0]    K_ONE  = KW'(1);
    localparam logic [AW-1:0]    HALF_F = AW'(F / 2);
    localparam logic [LGNIN:0]   NIN_W  = (LGNIN + 1)'(NIN);
`ifdef DSPSWITCH_MUTE_EN
    localparam logic [SW-1:0]    MUTE_SEL = SW'(NIN);
`endif

    localparam logic [0:0] ST_STEADY = 1'b0;
    localparam logic [0:0] ST_FADE   = 1'b1;

    // Control state
    logic [0:0]    r_state;
    logic [SW-1:0] r_cur_sel;
    logic [SW-1:0] r_nxt_sel;
    logic [KW-1:0] r_k;

    // Pipeline registers
    logic          r_v1;
    logic [DW-1:0] r_a;
    logic [DW-1:0] r_b;
    logic [KW-1:0] r_k1;
    logic          r_oce;
    logic [DW-1:0] r_sample;

    // Combinational signals
    logic [DW-1:0] w_ch [0:NCH-1];
    logic          w_sel_ok;
    logic [SW-1:0] w_req;
    logic          w_req_ok;
    logic [SW-1:0] w_b_sel;
    logic [KW-1:0] w_k_use;
    logic          w_done;
    logic [AW-1:0] w_a_ext;
    logic [AW-1:0] w_b_ext;
    logic [KW-1:0] w_wa;
    logic [AW-1:0] w_acc;

    // Unpack the input channels. Unused slots, including the mute slot, read zero.
    always_comb begin
        for (int i = 0; i < NCH; i++) begin
            w_ch[i] = '0;
        end
        for (int i = 0; i < NIN; i++) begin
            w_ch[i] = i_samples[i*DW +: DW];
        end
    end

    // Decide which channel the current sample requests, if any.
    always_comb begin
        w_sel_ok = ({1'b0, i_sel} < NIN_W);
        w_req    = SW'(i_sel);
        w_req_ok = w_sel_ok;
`ifdef DSPSWITCH_MUTE_EN
        if (i_mute) begin
            w_req    = MUTE_SEL;
            w_req_ok = 1'b1;
        end else if (!w_sel_ok && (r_cur_sel == MUTE_SEL)) begin
            // Leaving mute while the select is invalid falls back to channel 0.
            w_req    = '0;
            w_req_ok = 1'b1;
        end
`endif
    end

    // Choose the blend partner and the fade position used by this sample.
    always_comb begin
        w_b_sel = r_cur_sel;
        w_k_use = '0;
        if (r_state == ST_FADE) begin
            w_b_sel = r_nxt_sel;
            w_k_use = r_k + K_ONE;
        end else if (w_req_ok && (w_req != r_cur_sel)) begin
            w_b_sel = w_req;
            w_k_use = K_ONE;
        end
        w_done = (w_k_use == F_K);
    end

    // Advance the fade FSM. The sample with k=F commits the new channel.
    always_ff @(posedge i_clk or negedge i_areset_n) begin
        if (!i_areset_n) begin
            r_state   <= ST_STEADY;
            r_cur_sel <= '0;
            r_nxt_sel <= '0;
            r_k       <= '0;
        end else if (i_ce) begin
            if (w_done) begin
                r_cur_sel <= w_b_sel;
                r_nxt_sel <= w_b_sel;
                r_k       <= '0;
                r_state   <= ST_STEADY;
            end else if (w_k_use != '0) begin
                r_nxt_sel <= w_b_sel;
                r_k       <= w_k_use;
                r_state   <= ST_FADE;
            end
        end
    end

    // Stage 1: capture both operands and the weight for this sample.
    always_ff @(posedge i_clk or negedge i_areset_n) begin
        if (!i_areset_n) begin
            r_v1 <= 1'b0;
            r_a  <= '0;
            r_b  <= '0;
            r_k1 <= '0;
        end else begin
            r_v1 <= i_ce;
            if (i_ce) begin
                r_a  <= w_ch[r_cur_sel];
                r_b  <= w_ch[w_b_sel];
                r_k1 <= w_k_use;
            end
        end
    end

    // Weighted sum a*(F-k) + b*k + F/2. The products are formed modulo
    // 2^AW. Because the weights sum to F, the true result always fits in
    // AW bits, so the low bits are exact for signed operands.
    always_comb begin
        w_a_ext = {{(AW-DW){r_a[DW-1]}}, r_a};
        w_b_ext = {{(AW-DW){r_b[DW-1]}}, r_b};
        w_wa    = F_K - r_k1;
        w_acc   = w_a_ext * AW'(w_wa) + w_b_ext * AW'(r_k1) + HALF_F;
    end

    // Stage 2: round (shift by LGFADE) and present the output sample.
    always_ff @(posedge i_clk or negedge i_areset_n) begin
        if (!i_areset_n) begin
            r_oce    <= 1'b0;
            r_sample <= '0;
        end else begin
            r_oce <= r_v1;
            if (r_v1) begin
                r_sample <= DW'(w_acc >> LGFADE);
            end
        end
    end

    assign o_ce     = r_oce;
    assign o_sample = r_sample;
    assign o_busy   = (r_state == ST_FADE);
    assign o_sel    = r_cur_sel[LGNIN-1:0];

endmodule
